// File: rtl/rx_seriale_produttore.sv
// Serial byte receiver (start, 8 data LSB first, stop) feeding the sample-sweep
// consumer through a one-byte holding buffer and the dav_/rfd handshake.
module rx_seriale_produttore #(
  parameter int BIT_TIME = 16,
  parameter int CNT_W    = 5
) (
  input  logic       clock,
  input  logic       reset_,
  input  logic       rxd,
  input  logic       rfd,
  output logic       dav_,
  output logic [7:0] d7_d0,
  output logic       err_frame,
  output logic       err_ovr
);

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT1} rx_state_e;
  typedef enum logic [1:0] {H_WAIT, H_LOAD, H_DAV, H_REL} hs_state_e;

  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(BIT_TIME / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(BIT_TIME - 1);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic             rx_meta_q, rxs_q;
  rx_state_e        rx_q, rx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       nb_q, nb_d;
  logic [7:0]       sr_q, sr_d;
  logic             byte_valid, frame_bad;

  hs_state_e        hs_q, hs_d;
  logic             full_q, full_d, full_clr;
  logic [7:0]       buf_q, buf_d;
  logic             dav_q, dav_d;
  logic [7:0]       dout_q, dout_d;
  logic             err_frame_q, err_frame_d, err_ovr_q, err_ovr_d;

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      rx_meta_q   <= 1'b1;
      rxs_q       <= 1'b1;
      rx_q        <= RX_IDLE;
      cnt_q       <= '0;
      nb_q        <= '0;
      sr_q        <= '0;
      hs_q        <= H_WAIT;
      full_q      <= 1'b0;
      buf_q       <= '0;
      dav_q       <= 1'b1;
      dout_q      <= '0;
      err_frame_q <= 1'b0;
      err_ovr_q   <= 1'b0;
    end else begin
      rx_meta_q   <= rxd;
      rxs_q       <= rx_meta_q;
      rx_q        <= rx_d;
      cnt_q       <= cnt_d;
      nb_q        <= nb_d;
      sr_q        <= sr_d;
      hs_q        <= hs_d;
      full_q      <= full_d;
      buf_q       <= buf_d;
      dav_q       <= dav_d;
      dout_q      <= dout_d;
      err_frame_q <= err_frame_d;
      err_ovr_q   <= err_ovr_d;
    end
  end

  // Every sample lands mid-bit: half a bit after the synchronised falling edge, then whole bits.
  always_comb begin
    rx_d       = rx_q;
    cnt_d      = cnt_q;
    nb_d       = nb_q;
    sr_d       = sr_q;
    byte_valid = 1'b0;
    frame_bad  = 1'b0;
    case (rx_q)
      RX_IDLE: begin
        if (!rxs_q) begin
          rx_d  = RX_START;
          cnt_d = HALF_M1;
        end
      end
      RX_START: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - ONE;
        end else if (!rxs_q) begin
          rx_d  = RX_DATA;
          cnt_d = FULL_M1;
          nb_d  = '0;
        end else begin
          rx_d = RX_IDLE;
        end
      end
      RX_DATA: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - ONE;
        end else begin
          sr_d  = {rxs_q, sr_q[7:1]};
          cnt_d = FULL_M1;
          if (nb_q == 3'd7) rx_d = RX_STOP;
          else              nb_d = nb_q + 3'd1;
        end
      end
      RX_STOP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - ONE;
        end else if (rxs_q) begin
          byte_valid = 1'b1;
          rx_d       = RX_IDLE;
        end else begin
          frame_bad = 1'b1;
          rx_d      = RX_WAIT1;
        end
      end
      RX_WAIT1: begin
        if (rxs_q) rx_d = RX_IDLE;
      end
      default: rx_d = RX_IDLE;
    endcase
  end

  // dav_ is registered: it falls one cycle into H_DAV and rises on the edge that sees rfd=0.
  always_comb begin
    hs_d     = hs_q;
    dav_d    = dav_q;
    dout_d   = dout_q;
    full_clr = 1'b0;
    case (hs_q)
      H_WAIT: begin
        dav_d = 1'b1;
        if (full_q && rfd) hs_d = H_LOAD;
      end
      H_LOAD: begin
        dout_d = buf_q;
        hs_d   = H_DAV;
      end
      H_DAV: begin
        if (dav_q) begin
          dav_d = 1'b0;
        end else if (!rfd) begin
          dav_d    = 1'b1;
          full_clr = 1'b1;
          hs_d     = H_REL;
        end
      end
      H_REL: begin
        dav_d = 1'b1;
        hs_d  = H_WAIT;
      end
      default: hs_d = H_WAIT;
    endcase
  end

  // A byte arriving on the very cycle the buffer empties is taken, not flagged.
  always_comb begin
    full_d      = full_q;
    buf_d       = buf_q;
    err_ovr_d   = err_ovr_q;
    err_frame_d = err_frame_q | frame_bad;
    if (byte_valid) begin
      if (!full_q || full_clr) begin
        full_d = 1'b1;
        buf_d  = sr_q;
      end else begin
        err_ovr_d = 1'b1;
      end
    end else if (full_clr) begin
      full_d = 1'b0;
    end
  end

  assign dav_      = dav_q;
  assign d7_d0     = dout_q;
  assign err_frame = err_frame_q;
  assign err_ovr   = err_ovr_q;

endmodule

// File: tb/tb_rx_seriale_produttore.sv
// Directed bench for rx_seriale_produttore: serial frames in, handshake consumer
// model out, expected bytes held in a scoreboard queue.
module tb_rx_seriale_produttore;

  localparam int BT = 16;

  logic       clock;
  logic       reset_;
  logic       rxd;
  logic       rfd;
  logic       dav_;
  logic [7:0] d7_d0;
  logic       err_frame;
  logic       err_ovr;

  logic       cons_en;
  logic       rfd_c;
  logic       rfd_m;
  int         cons_hold;

  int         n_cmp;
  int         n_err;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       deliver;
    logic       exp_ferr;
  } vec_t;
  vec_t vecs[5];

  assign rfd = cons_en ? rfd_c : rfd_m;

  rx_seriale_produttore #(.BIT_TIME(BT), .CNT_W(5)) dut (
    .clock     (clock),
    .reset_    (reset_),
    .rxd       (rxd),
    .rfd       (rfd),
    .dav_      (dav_),
    .d7_d0     (d7_d0),
    .err_frame (err_frame),
    .err_ovr   (err_ovr)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // driver: one frame, each bit held BT clocks; line left at the stop-bit level
  task automatic send_frame(input logic [7:0] b, input logic stop);
    @(posedge clock); #1 rxd = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (BT) @(posedge clock);
      #1 rxd = b[i];
    end
    repeat (BT) @(posedge clock);
    #1 rxd = stop;
    repeat (BT) @(posedge clock);
    #1;
  endtask

  task automatic wait_dav(input logic lvl, input int budget, input string name);
    int i;
    i = 0;
    while (dav_ !== lvl && i < budget) begin
      @(negedge clock);
      i++;
    end
    n_cmp++;
    if (dav_ !== lvl) begin
      n_err++;
      $display("FAIL %s: dav_=%b after %0d clocks, expected %b", name, dav_, budget, lvl);
    end
  endtask

  task automatic wait_empty(input int budget, input string name);
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < budget) begin
      @(negedge clock);
      i++;
    end
    check(name, exp_q.size(), 0);
  endtask

  // consumer model: drops rfd on dav_, then stays busy for cons_hold clocks
  initial begin
    logic [7:0] got;
    logic       seen_low;
    forever begin
      @(negedge clock);
      if (cons_en && rfd_c && !dav_) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_delivery: got 0x%0h, expected no delivery", d7_d0);
        end else begin
          check("deliver_data", d7_d0, exp_q.pop_front());
        end
        got   = d7_d0;
        rfd_c = 1'b0;
        @(negedge clock);
        check("dav_release", dav_, 1'b1);
        check("data_hold", d7_d0, got);
        seen_low = 1'b0;
        repeat (cons_hold) begin
          @(negedge clock);
          if (!dav_) seen_low = 1'b1;
        end
        check("no_dav_while_busy", seen_low, 1'b0);
        rfd_c = 1'b1;
      end
    end
  end

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    cons_en   = 1'b1;
    rfd_c     = 1'b1;
    rfd_m     = 1'b1;
    cons_hold = 2;
    rxd       = 1'b1;
    reset_    = 1'b0;

    vecs[0] = '{8'h3C, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{8'h55, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{8'h0F, 1'b1, 1'b1, 1'b1};
    vecs[3] = '{8'h00, 1'b1, 1'b1, 1'b1};
    vecs[4] = '{8'hFF, 1'b1, 1'b1, 1'b1};

    repeat (3) @(posedge clock);
    #1;
    check("reset_dav", dav_, 1'b1);
    check("reset_data", d7_d0, 8'h00);
    check("reset_err_frame", err_frame, 1'b0);
    check("reset_err_ovr", err_ovr, 1'b0);
    reset_ = 1'b1;
    repeat (5) @(posedge clock);

    // 0xA5: dav_ falls exactly 3 clocks after the stop sample (clock 155 of the frame)
    exp_q.push_back(8'hA5);
    fork
      send_frame(8'hA5, 1'b1);
      begin
        @(posedge clock);
        repeat (157) @(posedge clock);
        #2 check("t1_dav_before", dav_, 1'b1);
        @(posedge clock);
        #2 check("t1_dav_low", dav_, 1'b0);
        check("t1_data", d7_d0, 8'hA5);
      end
    join
    wait_empty(100, "t1_drained");
    check("t1_err_frame", err_frame, 1'b0);
    check("t1_err_ovr", err_ovr, 1'b0);

    // glitch shorter than half a bit
    @(posedge clock); #1 rxd = 1'b0;
    repeat (4) @(posedge clock);
    #1 rxd = 1'b1;
    repeat (30) @(posedge clock);
    #1;
    check("t2_dav_idle", dav_, 1'b1);
    check("t2_err_frame", err_frame, 1'b0);

    for (int i = 0; i < 5; i++) begin
      if (vecs[i].deliver) exp_q.push_back(vecs[i].data);
      send_frame(vecs[i].data, vecs[i].stop);
      if (!vecs[i].stop) begin
        repeat (40) @(posedge clock);
        #1 rxd = 1'b1;
      end
      repeat (20) @(posedge clock);
      wait_empty(200, "vec_drained");
      check("vec_err_frame", err_frame, vecs[i].exp_ferr);
      check("vec_err_ovr", err_ovr, 1'b0);
    end

    // overrun while the consumer is busy with a long sweep
    cons_hold = 1030;
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    send_frame(8'h33, 1'b1);
    check("t4_err_ovr", err_ovr, 1'b1);
    check("t4_pending", exp_q.size(), 1);
    cons_hold = 2;
    wait_empty(1400, "t4_drained");
    repeat (10) @(posedge clock);

    // reset in the middle of the data bits of 0x99
    @(posedge clock); #1 rxd = 1'b0;
    repeat (BT) @(posedge clock);
    #1 rxd = 1'b1;
    repeat (BT) @(posedge clock);
    #1 rxd = 1'b0;
    repeat (BT / 2) @(posedge clock);
    #1 reset_ = 1'b0;
    #1;
    check("t5_dav", dav_, 1'b1);
    check("t5_data", d7_d0, 8'h00);
    check("t5_err_frame", err_frame, 1'b0);
    check("t5_err_ovr", err_ovr, 1'b0);
    rxd = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset_ = 1'b1;
    repeat (40) @(posedge clock);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1);
    wait_empty(200, "t5_drained");
    check("t5_err_frame_after", err_frame, 1'b0);
    repeat (10) @(posedge clock);

    // stop sample of 0x44 on the same edge that empties the buffer holding 0x77
    @(negedge clock);
    rfd_m   = 1'b1;
    cons_en = 1'b0;
    send_frame(8'h77, 1'b1);
    wait_dav(1'b0, 50, "t6_dav77");
    check("t6_data77", d7_d0, 8'h77);
    fork
      send_frame(8'h44, 1'b1);
      begin
        @(posedge clock);
        repeat (154) @(posedge clock);
        #1 rfd_m = 1'b0;
        @(posedge clock);
        #2 check("t6_release77", dav_, 1'b1);
        check("t6_err_ovr_edge", err_ovr, 1'b0);
        @(negedge clock);
        rfd_m = 1'b1;
      end
    join
    wait_dav(1'b0, 50, "t6_dav44");
    check("t6_data44", d7_d0, 8'h44);
    check("t6_err_ovr", err_ovr, 1'b0);
    @(negedge clock);
    rfd_m = 1'b0;
    wait_dav(1'b1, 10, "t6_release44");
    @(negedge clock);
    rfd_m = 1'b1;
    repeat (20) @(posedge clock);
    #1;
    check("final_idle_dav", dav_, 1'b1);
    check("final_queue", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
